ps2_host_tx: RTL

PS/2 host-to-device transmitter: sends one command byte (LED set 0xED, reset 0xFF, etc.) from the FPGA to the attached keyboard.
- Frame: start bit, 8 data bits LSB first, odd parity, stop bit, device acknowledge.
- Sits beside the keyboard receiver at top level and shares the same open-drain PS/2 clock/data pins.
- While it is busy, the top level gates the receiver off.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_line_filter.sv | 45 ++++
 rtl/ps2_host_tx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types, status codes and defaults for the PS/2 host transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StSend,
        StAck,
        StWaitIdle
    } ps2_tx_state_e;

    localparam logic [1:0] STAT_ACK     = 2'b00;
    localparam logic [1:0] STAT_NOACK   = 2'b01;
    localparam logic [1:0] STAT_TIMEOUT = 2'b10;

    // Defaults assume a 50 MHz system clock.
    localparam int unsigned DEF_INHIBIT_CYCLES = 5000;
    localparam int unsigned DEF_REQ_CYCLES     = 100;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;
    localparam int unsigned DEF_FILTER_CYCLES  = 8;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes and debounces one open-drain PS/2 line; flags accepted falls.
module ps2_line_filter #(
    parameter int unsigned FILTER_CYCLES = 8
) (
    input  logic clock,
    input  logic resetn,
    input  logic line_in,
    output logic level,
    output logic fall
);

    localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, fall_q;
    logic [CW-1:0] cnt_q;

    // A new level is taken only after FILTER_CYCLES consecutive differing samples.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
            fall_q  <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
                level_q <= sync2_q;
                fall_q  <= ~sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-clock frame, ack.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned REQ_CYCLES     = DEF_REQ_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned FILTER_CYCLES  = DEF_FILTER_CYCLES
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       tx_done,
    output logic [1:0] tx_status
);

    localparam int unsigned PHASE_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int unsigned TO_W      = $clog2(TIMEOUT_CYCLES + 1);

    ps2_tx_state_e state_q, state_d;
    logic [7:0]         data_q, data_d;
    logic               parity_q, parity_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic               clk_oe_q, clk_oe_d;
    logic               dat_oe_q, dat_oe_d;
    logic               done_q, done_d;
    logic [1:0]         status_q, status_d;
    logic               nack_q, nack_d;

    logic clk_level, clk_fall, dat_level, unused_dat_fall;
    logic timeout, finish;
    logic [1:0] finish_code;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
        .clock   (clock),
        .resetn  (resetn),
        .line_in (ps2_clk_in),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_dat_filter (
        .clock   (clock),
        .resetn  (resetn),
        .line_in (ps2_dat_in),
        .level   (dat_level),
        .fall    (unused_dat_fall)
    );

    assign timeout = (to_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        parity_d    = parity_q;
        bit_cnt_d   = bit_cnt_q;
        phase_d     = phase_q;
        to_d        = to_q;
        clk_oe_d    = clk_oe_q;
        dat_oe_d    = dat_oe_q;
        done_d      = 1'b0;
        status_d    = status_q;
        nack_d      = nack_q;
        finish      = 1'b0;
        finish_code = STAT_ACK;

        unique case (state_q)
            StIdle: begin
                if (tx_valid) begin
                    data_d   = tx_data;
                    parity_d = odd_parity(tx_data);
                    phase_d  = '0;
                    clk_oe_d = 1'b1;
                    dat_oe_d = 1'b0;
                    state_d  = StInhibit;
                end
            end
            StInhibit: begin
                if (phase_q == PHASE_W'(INHIBIT_CYCLES - 1)) begin
                    phase_d  = '0;
                    dat_oe_d = 1'b1;
                    state_d  = StReq;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            StReq: begin
                if (phase_q == PHASE_W'(REQ_CYCLES - 1)) begin
                    clk_oe_d  = 1'b0;
                    bit_cnt_d = '0;
                    to_d      = '0;
                    state_d   = StSend;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            StSend: begin
                if (timeout) begin
                    finish      = 1'b1;
                    finish_code = STAT_TIMEOUT;
                end else begin
                    to_d = to_q + TO_W'(1);
                    if (clk_fall) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q < 4'd8) begin
                            dat_oe_d = ~data_q[bit_cnt_q[2:0]];
                        end else if (bit_cnt_q == 4'd8) begin
                            dat_oe_d = ~parity_q;
                        end else begin
                            dat_oe_d = 1'b0;
                            state_d  = StAck;
                        end
                    end
                end
            end
            StAck: begin
                if (timeout) begin
                    finish      = 1'b1;
                    finish_code = STAT_TIMEOUT;
                end else begin
                    to_d = to_q + TO_W'(1);
                    if (clk_fall) begin
                        nack_d  = dat_level;
                        state_d = StWaitIdle;
                    end
                end
            end
            StWaitIdle: begin
                if (timeout) begin
                    finish      = 1'b1;
                    finish_code = STAT_TIMEOUT;
                end else begin
                    to_d = to_q + TO_W'(1);
                    if (clk_level && dat_level) begin
                        finish      = 1'b1;
                        finish_code = nack_q ? STAT_NOACK : STAT_ACK;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (finish) begin
            state_d  = StIdle;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            done_d   = 1'b1;
            status_d = finish_code;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= StIdle;
            data_q    <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            phase_q   <= '0;
            to_q      <= '0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            done_q    <= 1'b0;
            status_q  <= STAT_ACK;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            to_q      <= to_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
            done_q    <= done_d;
            status_q  <= status_d;
            nack_q    <= nack_d;
        end
    end

    assign tx_ready   = (state_q == StIdle);
    assign busy       = ~tx_ready;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign tx_done    = done_q;
    assign tx_status  = status_q;

endmodule
